// File: rtl/tt_pkg.sv
// Shared types and constants for the truth-table sweep/capture block.
package tt_pkg;

    localparam int N_IN = 7;
    localparam int TT_W = 128;

    typedef logic [TT_W-1:0] tt_t;
    typedef logic [N_IN-1:0] minterm_t;

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        SAMPLE,
        FINISH
    } sweep_state_e;

    localparam minterm_t LAST_MINTERM = minterm_t'(TT_W - 1);

endpackage

// File: rtl/tt_sweep_capture_if.sv
// Control, FUT and result signals of the sweep/capture block.
interface tt_sweep_capture_if
    import tt_pkg::*;
();

    logic       start;
    logic       abort;
    tt_t        expected;
    minterm_t   x_vec;
    logic       f_in;
    logic       busy;
    logic       done;
    tt_t        tt;
    logic       match;
    logic [7:0] mismatch_cnt;
    minterm_t   first_fail_idx;
    logic       first_fail_valid;

    modport master (
        output start, abort, expected, f_in,
        input  x_vec, busy, done, tt, match, mismatch_cnt,
               first_fail_idx, first_fail_valid
    );

    modport slave (
        input  start, abort, expected, f_in,
        output x_vec, busy, done, tt, match, mismatch_cnt,
               first_fail_idx, first_fail_valid
    );

endinterface

// File: rtl/tt_mismatch_tracker.sv
// Counts per-minterm mismatches against the reference and remembers the first one.
module tt_mismatch_tracker
    import tt_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clear,
    input  logic       sample,
    input  minterm_t   idx,
    input  logic       f_in,
    input  logic       exp_bit,
    output logic [7:0] mismatch_cnt,
    output minterm_t   first_fail_idx,
    output logic       first_fail_valid
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mismatch_cnt     <= '0;
            first_fail_idx   <= '0;
            first_fail_valid <= 1'b0;
        end else if (clear) begin
            mismatch_cnt     <= '0;
            first_fail_idx   <= '0;
            first_fail_valid <= 1'b0;
        end else if (sample && (f_in != exp_bit)) begin
            mismatch_cnt <= mismatch_cnt + 8'd1;
            if (!first_fail_valid) begin
                first_fail_idx   <= idx;
                first_fail_valid <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/tt_sweep_capture.sv
// Sweeps all 128 minterms into a 7-input FUT, captures its truth table and compares it to a reference.
module tt_sweep_capture
    import tt_pkg::*;
#(
    parameter int unsigned SETTLE = 0
) (
    input logic               clk,
    input logic               rst_n,
    tt_sweep_capture_if.slave bus
);

    localparam logic [3:0]   SETTLE_LAST = 4'((SETTLE > 0) ? SETTLE - 1 : 0);
    localparam sweep_state_e STEP_STATE  = (SETTLE > 0) ? DRIVE : SAMPLE;

    sweep_state_e state;
    minterm_t     x_vec;
    tt_t          tt;
    tt_t          exp_reg;
    logic         busy;
    logic         done;
    logic         match;
    logic [3:0]   settle_cnt;
    logic [7:0]   mismatch_cnt;
    logic         accept;
    logic         sample;

    assign accept = (state == IDLE) && bus.start;
    // An aborted SAMPLE cycle does not record its minterm.
    assign sample = (state == SAMPLE) && !bus.abort;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            x_vec      <= '0;
            tt         <= '0;
            exp_reg    <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            match      <= 1'b0;
            settle_cnt <= '0;
        end else begin
            done <= 1'b0;
            if ((state != IDLE) && bus.abort) begin
                state      <= IDLE;
                busy       <= 1'b0;
                match      <= 1'b0;
                x_vec      <= '0;
                settle_cnt <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (bus.start) begin
                            exp_reg    <= bus.expected;
                            tt         <= '0;
                            match      <= 1'b0;
                            x_vec      <= '0;
                            settle_cnt <= '0;
                            busy       <= 1'b1;
                            state      <= STEP_STATE;
                        end
                    end
                    DRIVE: begin
                        if (settle_cnt == SETTLE_LAST) begin
                            settle_cnt <= '0;
                            state      <= SAMPLE;
                        end else begin
                            settle_cnt <= settle_cnt + 4'd1;
                        end
                    end
                    SAMPLE: begin
                        tt[x_vec] <= bus.f_in;
                        if (x_vec == LAST_MINTERM) begin
                            state <= FINISH;
                        end else begin
                            x_vec <= x_vec + minterm_t'(1);
                            state <= STEP_STATE;
                        end
                    end
                    FINISH: begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        match <= (mismatch_cnt == 8'd0);
                        x_vec <= '0;
                        state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    tt_mismatch_tracker u_tracker (
        .clk              (clk),
        .rst_n            (rst_n),
        .clear            (accept),
        .sample           (sample),
        .idx              (x_vec),
        .f_in             (bus.f_in),
        .exp_bit          (exp_reg[x_vec]),
        .mismatch_cnt     (mismatch_cnt),
        .first_fail_idx   (bus.first_fail_idx),
        .first_fail_valid (bus.first_fail_valid)
    );

    assign bus.x_vec        = x_vec;
    assign bus.tt           = tt;
    assign bus.busy         = busy;
    assign bus.done         = done;
    assign bus.match        = match;
    assign bus.mismatch_cnt = mismatch_cnt;

endmodule

// File: tb/tb_tt_sweep_capture.sv
// Bench for tt_sweep_capture: table-driven sweeps on a combinational FUT plus a registered-FUT sweep.
module tb_tt_sweep_capture;
    import tt_pkg::*;

    typedef struct {
        int         mode;
        tt_t        exp;
        logic [7:0] cnt;
        minterm_t   ffi;
        logic       ffv;
        logic       match;
    } vec_t;

    typedef struct {
        tt_t        tt;
        logic [7:0] cnt;
        minterm_t   ffi;
        logic       ffv;
        logic       match;
    } sb_t;

    logic clk;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    int   mode0  = 0;
    vec_t vec[6];
    sb_t  sbq[$];
    tt_t  sig2 = 128'hfee8e8e8eee8e880fee8e888e8e8e880;
    logic p1, p2;

    tt_sweep_capture_if bus0();
    tt_sweep_capture_if bus2();

    tt_sweep_capture #(.SETTLE(0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
    tt_sweep_capture #(.SETTLE(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic fut(input int mode, input minterm_t x);
        case (mode)
            0:       return x[0];
            1:       return 1'b0;
            2:       return x[6];
            default: return ^x;
        endcase
    endfunction

    assign bus0.f_in = fut(mode0, bus0.x_vec);

    // Registered FUT with two pipeline stages for the SETTLE=2 instance.
    always_ff @(posedge clk) begin
        p1 <= sig2[bus2.x_vec];
        p2 <= p1;
    end
    assign bus2.f_in = p2;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, req);
        end
    endtask

    task automatic run_row(input int r, input bit pulses);
        sb_t m;
        sb_t g;
        int  cyc;
        for (int i = 0; i < TT_W; i++) m.tt[i] = fut(vec[r].mode, minterm_t'(i));
        m.cnt   = vec[r].cnt;
        m.ffi   = vec[r].ffi;
        m.ffv   = vec[r].ffv;
        m.match = vec[r].match;
        mode0         = vec[r].mode;
        bus0.expected = vec[r].exp;
        bus0.start    = 1'b1;
        sbq.push_back(m);
        tick();
        bus0.start    = 1'b0;
        bus0.expected = ~vec[r].exp;
        chk($sformatf("row%0d busy", r), 128'(bus0.busy), 128'(1'b1));
        cyc = 0;
        while (!bus0.done && cyc < 400) begin
            tick();
            cyc++;
            bus0.start = pulses && (cyc == 10 || cyc == 60);
        end
        bus0.start = 1'b0;
        chk($sformatf("row%0d latency", r), 128'(cyc), 128'(129));
        g = sbq.pop_front();
        chk($sformatf("row%0d tt", r), bus0.tt, g.tt);
        chk($sformatf("row%0d cnt", r), 128'(bus0.mismatch_cnt), 128'(g.cnt));
        chk($sformatf("row%0d ffi", r), 128'(bus0.first_fail_idx), 128'(g.ffi));
        chk($sformatf("row%0d ffv", r), 128'(bus0.first_fail_valid), 128'(g.ffv));
        chk($sformatf("row%0d match", r), 128'(bus0.match), 128'(g.match));
        chk($sformatf("row%0d busy_end", r), 128'(bus0.busy), 128'(1'b0));
        tick();
        chk($sformatf("row%0d done_pulse", r), 128'(bus0.done), 128'(1'b0));
    endtask

    initial begin
        tt_t aa;
        int  cyc;
        int  xbad;
        int  expx;
        bit  seen;

        aa = {32{4'hA}};
        vec[0] = '{0, aa, 8'd0, 7'd0, 1'b0, 1'b1};
        vec[1] = '{1, '1, 8'd128, 7'd0, 1'b1, 1'b0};
        vec[2] = '{0, aa ^ (tt_t'(1) << 77), 8'd1, 7'd77, 1'b1, 1'b0};
        vec[3] = '{2, {{64{1'b1}}, 64'd0}, 8'd0, 7'd0, 1'b0, 1'b1};
        vec[4] = '{3, '0, 8'd64, 7'd1, 1'b1, 1'b0};
        vec[5] = '{2, {1'b0, {63{1'b1}}, 64'd0}, 8'd1, 7'd127, 1'b1, 1'b0};

        rst_n = 1'b0;
        bus0.start = 1'b0; bus0.abort = 1'b0; bus0.expected = '0;
        bus2.start = 1'b0; bus2.abort = 1'b0; bus2.expected = '0;
        #1;
        chk("rst busy", 128'(bus0.busy), 128'(0));
        chk("rst done", 128'(bus0.done), 128'(0));
        chk("rst x_vec", 128'(bus0.x_vec), 128'(0));
        chk("rst tt", bus0.tt, '0);
        chk("rst cnt", 128'(bus0.mismatch_cnt), 128'(0));
        chk("rst ffv", 128'(bus0.first_fail_valid), 128'(0));
        chk("rst match", 128'(bus0.match), 128'(0));
        tick(); tick();
        #2 rst_n = 1'b1;
        tick();

        for (int r = 0; r < 6; r++) run_row(r, 1'b0);
        run_row(0, 1'b1);

        // Registered FUT, SETTLE=2: each minterm held three cycles
        bus2.expected = sig2;
        bus2.start = 1'b1;
        tick();
        bus2.start = 1'b0;
        bus2.expected = '0;
        cyc = 0;
        xbad = 0;
        while (!bus2.done && cyc < 1000) begin
            expx = (cyc / 3 > 127) ? 127 : cyc / 3;
            if (int'(bus2.x_vec) != expx) xbad++;
            tick();
            cyc++;
        end
        chk("s2 latency", 128'(cyc), 128'(385));
        chk("s2 x_step", 128'(xbad), 128'(0));
        chk("s2 match", 128'(bus2.match), 128'(1));
        chk("s2 tt", bus2.tt, sig2);
        tick();

        // start and abort together in IDLE: start wins; abort at x_vec=40
        mode0 = 0;
        bus0.expected = '0;
        bus0.start = 1'b1;
        bus0.abort = 1'b1;
        tick();
        bus0.start = 1'b0;
        bus0.abort = 1'b0;
        chk("start_beats_abort busy", 128'(bus0.busy), 128'(1));
        cyc = 0;
        while (bus0.x_vec != 7'd40 && cyc < 200) begin
            tick();
            cyc++;
        end
        chk("abort reach40", 128'(bus0.x_vec), 128'(40));
        bus0.abort = 1'b1;
        tick();
        bus0.abort = 1'b0;
        chk("abort busy", 128'(bus0.busy), 128'(0));
        chk("abort done", 128'(bus0.done), 128'(0));
        chk("abort match", 128'(bus0.match), 128'(0));
        chk("abort cnt", 128'(bus0.mismatch_cnt), 128'(20));
        chk("abort ffi", 128'(bus0.first_fail_idx), 128'(1));
        chk("abort ffv", 128'(bus0.first_fail_valid), 128'(1));
        chk("abort tt", bus0.tt, {88'd0, 40'hAAAAAAAAAA});
        seen = 1'b0;
        for (int i = 0; i < 150; i++) begin
            tick();
            seen |= bus0.done | bus0.busy;
        end
        chk("abort no_done", 128'(seen), 128'(0));
        run_row(0, 1'b0);

        // start presented during the FINISH cycle
        mode0 = 0;
        bus0.expected = aa;
        bus0.start = 1'b1;
        tick();
        bus0.start = 1'b0;
        for (int i = 0; i < 128; i++) tick();
        bus0.start = 1'b1;
        tick();
        chk("fin_start done", 128'(bus0.done), 128'(1));
        chk("fin_start busy", 128'(bus0.busy), 128'(0));
        tick();
        bus0.start = 1'b0;
        chk("fin_start accepted", 128'(bus0.busy), 128'(1));
        bus0.abort = 1'b1;
        tick();
        bus0.abort = 1'b0;
        chk("fin_start aborted", 128'(bus0.busy), 128'(0));

        // async reset mid-sweep at x_vec=100
        mode0 = 0;
        bus0.expected = '1;
        bus0.start = 1'b1;
        tick();
        bus0.start = 1'b0;
        cyc = 0;
        while (bus0.x_vec != 7'd100 && cyc < 200) begin
            tick();
            cyc++;
            bus0.start = (cyc == 20);
        end
        bus0.start = 1'b0;
        chk("rst_mid reach100", 128'(bus0.x_vec), 128'(100));
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid busy", 128'(bus0.busy), 128'(0));
        chk("rst_mid x_vec", 128'(bus0.x_vec), 128'(0));
        chk("rst_mid tt", bus0.tt, '0);
        chk("rst_mid cnt", 128'(bus0.mismatch_cnt), 128'(0));
        chk("rst_mid ffi", 128'(bus0.first_fail_idx), 128'(0));
        chk("rst_mid ffv", 128'(bus0.first_fail_valid), 128'(0));
        chk("rst_mid match", 128'(bus0.match), 128'(0));
        #2 rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 140; i++) begin
            tick();
            seen |= bus0.done | bus0.busy;
        end
        chk("rst_mid no_done", 128'(seen), 128'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tt_sweep_capture.md
Name: tt_sweep_capture

Overview:
- Sequential characterisation stage that wraps a 7-input single-output combinational function under test (FUT), such as a majority-gate classification network.
- Upstream, it sweeps all 128 input minterms into the FUT's x0..x6 inputs.
- Downstream, it samples the FUT output per minterm and assembles the 128-bit truth table.
- Compares the table against an expected signature and reports match, mismatch count and first failing minterm.

Parameters:
- N_IN, 7, number of FUT inputs; fixed at 7 for this block.
- TT_W, 128, truth-table width (2**N_IN).
- SETTLE, 0, wait cycles between driving a minterm and sampling f_in; range 0..15. Use 0 for a purely combinational FUT, >0 for a registered FUT.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request sweep; accepted only in IDLE.
- abort  in  1  cancel sweep in progress; return to IDLE without done.
- expected  in  TT_W  reference truth table; captured on start accept.
- x_vec  out  N_IN  minterm driven to FUT; x_vec[0]=x0 … x_vec[6]=x6.
- f_in  in  1  FUT output for the current x_vec.
- busy  out  1  high from start accept until done or abort.
- done  out  1  one-cycle pulse when the sweep completes.
- tt  out  TT_W  captured truth table; tt[i] = f(x_vec=i), so tt[127] = f(all ones); stable after done.
- match  out  1  tt == expected; valid when done, held until next start.
- mismatch_cnt  out  8  number of differing bits, 0..128.
- first_fail_idx  out  N_IN  lowest minterm index with tt[i] != expected[i].
- first_fail_valid  out  1  at least one mismatch seen.

Behaviour:

Reset (async, rst_n low):
- State = IDLE.
- x_vec, tt, mismatch_cnt, first_fail_idx = 0.
- busy, done, match, first_fail_valid = 0.
- expected register = 0.

FSM states: IDLE, DRIVE, SAMPLE, FINISH.

IDLE:
- On start=1: register expected, clear tt/mismatch_cnt/first_fail_*/match, set x_vec=0, busy=1.
- Next state: DRIVE if SETTLE>0, else SAMPLE.
- start while busy is ignored, with no side effects.

DRIVE:
- Settle counter counts SETTLE cycles with x_vec held, then moves to SAMPLE.

SAMPLE (one cycle):
- tt[x_vec] <= f_in.
- If f_in != expected_reg[x_vec]: mismatch_cnt += 1.
- If that is the first mismatch: capture first_fail_idx = x_vec and set first_fail_valid.
- If x_vec == 127: go to FINISH.
- Else: x_vec += 1 and go to DRIVE (SETTLE>0) or stay in SAMPLE (SETTLE=0).

FINISH (one cycle):
- done=1, busy=0, match = (mismatch_cnt == 0).
- x_vec returns to 0; next state IDLE.

Latency:
- Start accept edge to done pulse = 128*(SETTLE+1)+1 cycles.
- SETTLE=0 gives 129 cycles.

Boundary conditions:
- x_vec never wraps during a sweep; the terminal sample at index 127 ends the sweep.
- mismatch_cnt is 8 bits so that 128 is representable without overflow.
- abort in any non-IDLE state:
  - Next cycle is IDLE, busy=0, no done.
  - tt, mismatch_cnt and first_fail_* keep partial values.
  - match forced to 0.
- abort and start together in IDLE: start wins; abort is a no-op in IDLE.
- Changes on the expected port after start accept have no effect.
- rst_n asserted mid-sweep clears everything immediately. No done pulse follows reset release.
- start in the FINISH cycle is ignored; it is accepted in the following IDLE cycle.

Decomposition:
- Package tt_pkg holds:
  - Constants N_IN=7 and TT_W=128.
  - Typedef tt_t (logic [TT_W-1:0]) and minterm_t (logic [N_IN-1:0]).
  - State enum sweep_state_e {IDLE, DRIVE, SAMPLE, FINISH}.
- One natural sub-module: tt_mismatch_tracker.
  - Owns mismatch_cnt and first_fail_idx/first_fail_valid.
  - Takes sample strobe, index, f_in and the expected bit.
- All other logic lives in tt_sweep_capture.

Test Plan:
1. FUT f=x0, expected=128'hAAAA_AAAA_AAAA_AAAA_AAAA_AAAA_AAAA_AAAA, SETTLE=0 -> done exactly 129 cycles after start; tt equals expected; match=1; mismatch_cnt=0; first_fail_valid=0.
2. FUT = 3-of-7-style majority-gate network, expected=128'hfee8e8e8eee8e880fee8e888e8e8e880, SETTLE=2 -> done at 385 cycles; match=1; x_vec observed stepping 0..127, each held 3 cycles.
3. FUT f=0, expected all ones -> mismatch_cnt=128; first_fail_idx=0; first_fail_valid=1; match=0; tt=0.
4. FUT f=x0, expected = 128'hAAAA…AAAA with bit 77 flipped -> mismatch_cnt=1; first_fail_idx=77; match=0.
5. abort asserted when x_vec=40 -> IDLE next cycle, busy=0, no done, match=0. A fresh start afterwards completes normally in 129 cycles.
6. rst_n pulsed low at x_vec=100, plus start pulses while busy -> all outputs 0 asynchronously; no done after release; start pulses while busy had no effect on the timing of case 1.
